// File: rtl/acorn_decrypt.sv
// acorn_decrypt: ACORN-128 decryption phase, bit-serial (one state step per clk), then message padding.
// Latency: byte handshake in cycle t -> pt_valid_o from cycle t+9; padding takes PAD_LEN cycles; >= 10 cycles/byte.
// Backpressure: ct_ready_o is high only in WAIT, so an unacknowledged plaintext byte stalls ciphertext intake.
// Ports: clk, rst (async, active-high); start_i/empty_i/state_in load a new phase from the AD-phase state;
//   ct_valid_i/ct_byte_i/ct_last_i/ct_ready_o ciphertext in; pt_valid_o/pt_byte_o/pt_ready_i plaintext out;
//   done_o + state_out hand the final state to finalization.
// Option: define ACORN_DEC_KSOUT_EN to add ks_byte_o, the keystream bits used for the current byte.
module acorn_decrypt #(
    parameter int PAD_LEN = 256,
    parameter int CA_ONES = 128
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start_i,
    input  logic         empty_i,
    input  logic [292:0] state_in,
    input  logic         ct_valid_i,
    input  logic [7:0]   ct_byte_i,
    input  logic         ct_last_i,
    output logic         ct_ready_o,
    output logic         pt_valid_o,
    output logic [7:0]   pt_byte_o,
`ifdef ACORN_DEC_KSOUT_EN
    output logic [7:0]   ks_byte_o,
`endif
    input  logic         pt_ready_i,
    output logic         done_o,
    output logic [292:0] state_out
);

    localparam logic [7:0] PAD_LAST  = 8'(PAD_LEN - 1);
    localparam logic [8:0] CA_ONES_W = 9'(CA_ONES);

    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_BITS, S_OUT, S_PAD, S_DONE} fsm_t;

    fsm_t         cur, nxt;
    logic [292:0] st;
    logic [292:0] st_step;
    logic [7:0]   ct_q;
    logic         last_q;
    logic [2:0]   bit_cnt;
    logic [7:0]   pad_cnt;
    logic [7:0]   pt_q;
    logic         ks;
    logic         p;
    logic         step_m;
    logic         step_ca;

    function automatic logic maj(input logic x, input logic y, input logic z);
        return (x & y) ^ (x & z) ^ (y & z);
    endfunction

    function automatic logic ch(input logic x, input logic y, input logic z);
        return (x & y) ^ (~x & z);
    endfunction

    // Six LFSR-section feedbacks; every right-hand side uses the pre-update bits.
    function automatic logic [292:0] lin_update(input logic [292:0] s);
        logic [292:0] t;
        t      = s;
        t[289] = s[289] ^ s[235] ^ s[230];
        t[230] = s[230] ^ s[196] ^ s[193];
        t[193] = s[193] ^ s[160] ^ s[154];
        t[154] = s[154] ^ s[111] ^ s[107];
        t[107] = s[107] ^ s[66]  ^ s[61];
        t[61]  = s[61]  ^ s[23]  ^ s[0];
        return t;
    endfunction

    // Keystream bit from taps of the linearly updated state.
    function automatic logic ksg(input logic t12, input logic t154, input logic t235, input logic t61,
                                 input logic t193, input logic t230, input logic t111, input logic t66);
        return t12 ^ t154 ^ maj(t235, t61, t193) ^ ch(t230, t111, t66);
    endfunction

    function automatic logic [292:0] state_update128(input logic [292:0] s, input logic m,
                                                     input logic ca, input logic cb);
        logic [292:0] t;
        logic         k;
        logic         f;
        t = lin_update(s);
        k = ksg(t[12], t[154], t[235], t[61], t[193], t[230], t[111], t[66]);
        f = t[0] ^ ~t[107] ^ maj(t[244], t[23], t[160]) ^ (ca & t[196]) ^ (cb & k) ^ m;
        return {f, t[292:1]};
    endfunction

    // Keystream for the current bit, from the same updated copy the step uses.
    always_comb begin
        logic [292:0] t;
        t  = lin_update(st);
        ks = ksg(t[12], t[154], t[235], t[61], t[193], t[230], t[111], t[66]);
    end

    assign p = ct_q[bit_cnt] ^ ks;

    // Message bit and ca select: decryption feeds back plaintext, padding injects a single 1.
    always_comb begin
        step_m  = 1'b0;
        step_ca = 1'b0;
        if (cur == S_BITS) begin
            step_m  = p;
            step_ca = 1'b1;
        end else if (cur == S_PAD) begin
            step_m  = (pad_cnt == 8'd0);
            step_ca = ({1'b0, pad_cnt} < CA_ONES_W);
        end
    end

    assign st_step = state_update128(st, step_m, step_ca, 1'b0);

    // FSM: state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cur <= S_IDLE;
        else     cur <= nxt;
    end

    // FSM: next state
    always_comb begin
        nxt = cur;
        case (cur)
            S_IDLE, S_DONE: if (start_i)              nxt = empty_i ? S_PAD : S_WAIT;
            S_WAIT:         if (ct_valid_i)           nxt = S_BITS;
            S_BITS:         if (bit_cnt == 3'd7)      nxt = S_OUT;
            S_OUT:          if (pt_ready_i)           nxt = last_q ? S_PAD : S_WAIT;
            S_PAD:          if (pad_cnt == PAD_LAST)  nxt = S_DONE;
            default:                                  nxt = S_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        ct_ready_o = 1'b0;
        pt_valid_o = 1'b0;
        done_o     = 1'b0;
        case (cur)
            S_WAIT:  ct_ready_o = 1'b1;
            S_OUT:   pt_valid_o = 1'b1;
            S_DONE:  done_o     = 1'b1;
            default: ;
        endcase
    end

    // Datapath
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st      <= '0;
            ct_q    <= '0;
            last_q  <= 1'b0;
            bit_cnt <= '0;
            pad_cnt <= '0;
            pt_q    <= '0;
        end else begin
            if ((cur == S_IDLE || cur == S_DONE) && start_i)
                st <= state_in;
            else if (cur == S_BITS || cur == S_PAD)
                st <= st_step;

            if (cur == S_WAIT && ct_valid_i) begin
                ct_q   <= ct_byte_i;
                last_q <= ct_last_i;
            end

            if (cur == S_BITS)
                pt_q[bit_cnt] <= p;

            if (nxt == S_BITS && cur != S_BITS)
                bit_cnt <= '0;
            else if (cur == S_BITS && bit_cnt != 3'd7)
                bit_cnt <= bit_cnt + 3'd1;

            if (nxt == S_PAD && cur != S_PAD)
                pad_cnt <= '0;
            else if (cur == S_PAD && pad_cnt != PAD_LAST)
                pad_cnt <= pad_cnt + 8'd1;
        end
    end

`ifdef ACORN_DEC_KSOUT_EN
    logic [7:0] ks_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst)              ks_q <= '0;
        else if (cur == S_BITS) ks_q[bit_cnt] <= ks;
    end
    assign ks_byte_o = ks_q;
`endif

    assign pt_byte_o = pt_q;
    assign state_out = st;

endmodule

// File: tb/tb_acorn_decrypt.sv
// tb_acorn_decrypt: directed bench for acorn_decrypt against a behavioural ACORN-128 reference.
// Covers reset, zero-length padding, 16-byte loopback, plaintext backpressure, ignored inputs.
// Build with ACORN_DEC_KSOUT_EN defined to also check ks_byte_o.
module tb_acorn_decrypt;

    logic         clk = 1'b0;
    logic         rst;
    logic         start_i;
    logic         empty_i;
    logic [292:0] state_in;
    logic         ct_valid_i;
    logic [7:0]   ct_byte_i;
    logic         ct_last_i;
    logic         ct_ready_o;
    logic         pt_valid_o;
    logic [7:0]   pt_byte_o;
    logic         pt_ready_i;
    logic         done_o;
    logic [292:0] state_out;
`ifdef ACORN_DEC_KSOUT_EN
    logic [7:0]   ks_byte_o;
    logic [7:0]   ks_seen;
`endif

    always #5 clk = ~clk;

    acorn_decrypt dut (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start_i),
        .empty_i    (empty_i),
        .state_in   (state_in),
        .ct_valid_i (ct_valid_i),
        .ct_byte_i  (ct_byte_i),
        .ct_last_i  (ct_last_i),
        .ct_ready_o (ct_ready_o),
        .pt_valid_o (pt_valid_o),
        .pt_byte_o  (pt_byte_o),
`ifdef ACORN_DEC_KSOUT_EN
        .ks_byte_o  (ks_byte_o),
`endif
        .pt_ready_i (pt_ready_i),
        .done_o     (done_o),
        .state_out  (state_out)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [292:0] got, input logic [292:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // ---------------- reference model ----------------
    function automatic logic [292:0] m_lin(input logic [292:0] s);
        logic [292:0] t;
        t = s;
        t[289] = s[289] ^ s[235] ^ s[230];
        t[230] = s[230] ^ s[196] ^ s[193];
        t[193] = s[193] ^ s[160] ^ s[154];
        t[154] = s[154] ^ s[111] ^ s[107];
        t[107] = s[107] ^ s[66]  ^ s[61];
        t[61]  = s[61]  ^ s[23]  ^ s[0];
        return t;
    endfunction

    function automatic logic m_ks(input logic [292:0] s);
        logic [292:0] t;
        logic a, b, c;
        t = m_lin(s);
        a = t[235]; b = t[61]; c = t[193];
        return t[12] ^ t[154] ^ ((a & b) | (a & c) | (b & c)) ^ (t[230] ? t[111] : t[66]);
    endfunction

    function automatic logic [292:0] m_upd(input logic [292:0] s, input logic m, input logic ca, input logic cb);
        logic [292:0] t;
        logic a, b, c, f;
        t = m_lin(s);
        a = t[244]; b = t[23]; c = t[160];
        f = t[0] ^ ~t[107] ^ ((a & b) | (a & c) | (b & c)) ^ (ca & t[196]) ^ (cb & m_ks(s)) ^ m;
        return {f, t[292:1]};
    endfunction

    // key = 0, iv = 0 init followed by empty associated data
    function automatic logic [292:0] m_ad_state();
        logic [292:0] s;
        s = '0;
        for (int i = 0; i < 1792; i++) s = m_upd(s, (i == 256), 1'b1, 1'b1);
        for (int j = 0; j < 256; j++)  s = m_upd(s, (j == 0), (j < 128), 1'b1);
        return s;
    endfunction

    function automatic logic [292:0] m_pad(input logic [292:0] si);
        logic [292:0] s;
        s = si;
        for (int j = 0; j < 256; j++) s = m_upd(s, (j == 0), (j < 128), 1'b0);
        return s;
    endfunction

    task automatic m_enc(input logic [7:0] pt, input logic [292:0] si, output logic [7:0] ct, output logic [292:0] so);
        so = si;
        for (int k = 0; k < 8; k++) begin
            ct[k] = pt[k] ^ m_ks(so);
            so    = m_upd(so, pt[k], 1'b1, 1'b0);
        end
    endtask

    task automatic m_dec(input logic [7:0] ct, input logic [292:0] si, output logic [7:0] pt, output logic [292:0] so);
        so = si;
        for (int k = 0; k < 8; k++) begin
            pt[k] = ct[k] ^ m_ks(so);
            so    = m_upd(so, pt[k], 1'b1, 1'b0);
        end
    endtask

    // ---------------- stimulus helpers ----------------
    logic [292:0] ad;
    logic [292:0] enc_final;
    logic [7:0]   ct_v [16];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_session(input logic [292:0] s, input logic empty);
        state_in = s;
        empty_i  = empty;
        start_i  = 1'b1;
        tick();
        start_i  = 1'b0;
        empty_i  = 1'b0;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (!done_o && cyc < 400) begin
            tick();
            cyc++;
        end
    endtask

    // One ciphertext byte through the DUT; optional start_i pulse while BITS is running.
    task automatic dec_byte(input logic [7:0] c, input logic last, input logic poke,
                            output logic [7:0] p, output int lat);
        int w;
        w = 0;
        while (!ct_ready_o && w < 50) begin
            tick();
            w++;
        end
        chk("ct_ready", 293'(ct_ready_o), 293'(1));
        ct_valid_i = 1'b1;
        ct_byte_i  = c;
        ct_last_i  = last;
        tick();
        ct_valid_i = 1'b0;
        ct_last_i  = 1'b0;
        ct_byte_i  = 8'h00;
        lat = 0;
        while (!pt_valid_o && lat < 50) begin
            start_i = poke && (lat == 2);
            if (poke) begin
                state_in = '1;
                empty_i  = 1'b1;
            end
            tick();
            lat++;
        end
        start_i = 1'b0;
        empty_i = 1'b0;
        p = pt_byte_o;
`ifdef ACORN_DEC_KSOUT_EN
        ks_seen = ks_byte_o;
`endif
        tick();
    endtask

    task automatic run_msg(input logic poke);
        logic [7:0] p;
        int lat, cyc;
        start_session(ad, 1'b0);
        for (int i = 0; i < 16; i++) begin
            dec_byte(ct_v[i], (i == 15), poke && (i == 3), p, lat);
            chk($sformatf("pt_byte[%0d]", i), 293'(p), 293'(8'(i)));
`ifdef ACORN_DEC_KSOUT_EN
            chk($sformatf("ks_xor_ct[%0d]", i), 293'(ks_seen ^ ct_v[i]), 293'(8'(i)));
`endif
            if (i == 0) chk("latency", 293'(lat), 293'(8));
        end
        if (poke) begin
            ct_valid_i = 1'b1;
            ct_byte_i  = 8'h5A;
        end
        wait_done(cyc);
        ct_valid_i = 1'b0;
        ct_byte_i  = 8'h00;
        chk("msg_pad_cycles", 293'(cyc), 293'(256));
        chk("msg_final_state", state_out, enc_final);
        chk("msg_done", 293'(done_o), 293'(1));
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [292:0] s, bp_final, snap;
        logic [7:0]   c, bp_pt;
        int           cyc, w;

        rst = 1'b1;
        start_i = 1'b0; empty_i = 1'b0; state_in = '0;
        ct_valid_i = 1'b0; ct_byte_i = 8'h00; ct_last_i = 1'b0; pt_ready_i = 1'b1;

        ad = m_ad_state();
        s  = ad;
        for (int i = 0; i < 16; i++) begin
            m_enc(8'(i), s, c, s);
            ct_v[i] = c;
        end
        enc_final = m_pad(s);

        // reset state
        repeat (3) tick();
        chk("rst_state", state_out, '0);
        chk("rst_ct_ready", 293'(ct_ready_o), 293'(0));
        chk("rst_pt_valid", 293'(pt_valid_o), 293'(0));
        chk("rst_pt_byte", 293'(pt_byte_o), 293'(0));
        chk("rst_done", 293'(done_o), 293'(0));
`ifdef ACORN_DEC_KSOUT_EN
        chk("rst_ks_byte", 293'(ks_byte_o), 293'(0));
`endif
        rst = 1'b0;
        tick();

        // zero-length message: straight to padding
        start_session(ad, 1'b1);
        wait_done(cyc);
        chk("empty_pad_cycles", 293'(cyc), 293'(256));
        chk("empty_state", state_out, m_pad(ad));
        chk("empty_done", 293'(done_o), 293'(1));

        // 16-byte loopback
        run_msg(1'b0);

        // plaintext backpressure on 0xA5
        m_dec(8'hA5, ad, bp_pt, s);
        bp_final = m_pad(s);
        start_session(ad, 1'b0);
        pt_ready_i = 1'b0;
        ct_valid_i = 1'b1; ct_byte_i = 8'hA5; ct_last_i = 1'b1;
        tick();
        ct_valid_i = 1'b0; ct_last_i = 1'b0;
        w = 0;
        while (!pt_valid_o && w < 50) begin
            tick();
            w++;
        end
        chk("bp_pt_valid", 293'(pt_valid_o), 293'(1));
        snap = state_out;
        for (int i = 0; i < 20; i++) begin
            ct_valid_i = 1'b1;
            tick();
            chk("bp_hold_valid", 293'(pt_valid_o), 293'(1));
            chk("bp_hold_byte", 293'(pt_byte_o), 293'(bp_pt));
            chk("bp_hold_ct_ready", 293'(ct_ready_o), 293'(0));
            chk("bp_hold_state", state_out, snap);
        end
        ct_valid_i = 1'b0;
        pt_ready_i = 1'b1;
        tick();
        wait_done(cyc);
        chk("bp_final_state", state_out, bp_final);

        // async reset in the middle of padding
        start_session(ad, 1'b1);
        repeat (100) tick();
        #3 rst = 1'b1;
        #1;
        chk("midpad_rst_state", state_out, '0);
        chk("midpad_rst_done", 293'(done_o), 293'(0));
        tick();
        chk("midpad_rst_state_edge", state_out, '0);
        chk("midpad_rst_ct_ready", 293'(ct_ready_o), 293'(0));
        rst = 1'b0;
        tick();

        // async reset with a plaintext byte pending
        start_session(ad, 1'b0);
        pt_ready_i = 1'b0;
        ct_valid_i = 1'b1; ct_byte_i = 8'hA5; ct_last_i = 1'b0;
        tick();
        ct_valid_i = 1'b0;
        repeat (9) tick();
        rst = 1'b1;
        #1;
        chk("out_rst_pt_valid", 293'(pt_valid_o), 293'(0));
        chk("out_rst_pt_byte", 293'(pt_byte_o), 293'(0));
        chk("out_rst_state", state_out, '0);
`ifdef ACORN_DEC_KSOUT_EN
        chk("out_rst_ks_byte", 293'(ks_byte_o), 293'(0));
`endif
        tick();
        rst = 1'b0;
        pt_ready_i = 1'b1;
        tick();

        // ignored start_i during BITS and ct_valid_i during PAD
        run_msg(1'b1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
